// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES engine: block width, maximum round
// count and the controller state encoding.
package aes_pkg;
  localparam int AES_BLK_W  = 128;
  localparam int AES_NR_MAX = 14;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} aes_iter_state_t;
endpackage

// File: rtl/aes64.sv
// Combinational RV64-style AES half-round datapath: produces two output columns
// (low or high half) of one encrypt or equivalent-inverse decrypt round.
module aes64 (
  input  logic        valid,
  output logic        ready,
  input  logic        hi,
  input  logic        op_enc,
  input  logic        op_dec,
  input  logic        op_sub,
  input  logic        op_imix,
  input  logic        mix,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic [63:0] rd
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  // Circulant column mix; row r uses coefficient m[(k-r) mod 4] for input byte k.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [31:0] m;
    logic [31:0] o;
    m = inv ? 32'h090d0b0e : 32'h01010302;
    o = '0;
    for (int row = 0; row < 4; row++)
      for (int k = 0; k < 4; k++)
        o[8*row +: 8] = o[8*row +: 8] ^ gmul(c[8*k +: 8], m[8*((k - row) & 3) +: 8]);
    return o;
  endfunction

  logic [127:0] st;
  logic [63:0]  round_res;
  logic [63:0]  sub_res;
  logic [63:0]  imix_res;

  assign ready    = valid;
  assign st       = {rs2, rs1};
  assign imix_res = {mix_col(rs1[63:32], 1'b1), mix_col(rs1[31:0], 1'b1)};

  always_comb begin
    logic [31:0] col;
    int oc;
    int src;
    col       = '0;
    oc        = 0;
    src       = 0;
    round_res = '0;
    sub_res   = '0;
    for (int c = 0; c < 2; c++) begin
      oc = c + (hi ? 2 : 0);
      for (int r = 0; r < 4; r++) begin
        src = op_dec ? ((oc - r) & 3) : ((oc + r) & 3);
        col[8*r +: 8] = op_dec ? inv_sbox(st[8*(r + 4*src) +: 8])
                               : sbox(st[8*(r + 4*src) +: 8]);
      end
      if (mix) col = mix_col(col, op_dec);
      round_res[32*c +: 32] = col;
    end
    for (int i = 0; i < 8; i++) sub_res[8*i +: 8] = sbox(rs1[8*i +: 8]);
  end

  always_comb begin
    rd = '0;
    if (valid) begin
      if (op_sub)               rd = sub_res;
      else if (op_imix)         rd = imix_res;
      else if (op_enc || op_dec) rd = round_res;
    end
  end
endmodule

// File: rtl/aes64_iter_core.sv
// Iterative AES block engine: one block at a time, two aes64 passes per round,
// round keys from a software-written (NR+1)-entry table.
module aes64_iter_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                 g_clk,
  input  logic                 g_rst,
  input  logic                 key_we,
  input  logic [3:0]           key_idx,
  input  logic [AES_BLK_W-1:0] key_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_dec,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data
);
  localparam int            RW   = $clog2(AES_NR_MAX + 1);
  localparam logic [RW-1:0] NR_L = RW'(NR);

  aes_iter_state_t      state_q, state_d;
  logic [AES_BLK_W-1:0] s_q, s_d;
  logic [63:0]          tmp_lo_q, tmp_lo_d;
  logic [RW-1:0]        r_q, r_d;
  logic                 dec_q, dec_d;
  logic [AES_BLK_W-1:0] rk_q [0:NR];
  logic [AES_BLK_W-1:0] rk_d [0:NR];
  logic [RW-1:0]        k_idx;
  logic                 aes_valid;
  logic                 aes_ready;
  logic [63:0]          aes_rd;

  assign aes_valid = (state_q == LO) || (state_q == HI);
  assign k_idx     = dec_q ? (NR_L - r_q) : r_q;

  aes64 u_aes64 (
    .valid   (aes_valid),
    .ready   (aes_ready),
    .hi      (state_q == HI),
    .op_enc  (~dec_q),
    .op_dec  (dec_q),
    .op_sub  (1'b0),
    .op_imix (1'b0),
    .mix     (r_q != NR_L),
    .rs1     (s_q[63:0]),
    .rs2     (s_q[127:64]),
    .rd      (aes_rd)
  );

  // Table writes only land while idle so a running block never sees a key change.
  always_comb begin
    rk_d = rk_q;
    if (key_we && !g_rst && (state_q == IDLE) && (key_idx <= NR_L))
      rk_d[key_idx] = key_data;
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    tmp_lo_d = tmp_lo_q;
    r_d      = r_q;
    dec_d    = dec_q;
    case (state_q)
      IDLE: if (in_valid) begin
        s_d     = in_data ^ (in_dec ? rk_q[NR] : rk_q[0]);
        dec_d   = in_dec;
        r_d     = RW'(1);
        state_d = LO;
      end
      LO: if (aes_ready) begin
        tmp_lo_d = aes_rd;
        state_d  = HI;
      end
      HI: if (aes_ready) begin
        s_d = {aes_rd, tmp_lo_q} ^ rk_q[k_idx];
        if (r_q == NR_L) state_d = DONE;
        else begin
          r_d     = r_q + 1'b1;
          state_d = LO;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      dec_q   <= dec_d;
    end
    s_q      <= s_d;
    tmp_lo_q <= tmp_lo_d;
    rk_q     <= rk_d;
  end

  assign in_ready  = (state_q == IDLE) && !g_rst;
  assign out_valid = (state_q == DONE) && !g_rst;
  assign out_data  = out_valid ? s_q : '0;
endmodule
